// File: rtl/data_mem_responder.sv
// Purpose : single-port data memory answering the CPU data bus, with a host preload/inspect port,
//           a post-reset zeroing walk and a saturating count of CPU stores.
// Latency : CPU read 1 cycle (registered d_datain); host access acked 1 cycle after acceptance.
// Backpr. : CPU writes take priority; a host request stalls (fields held) until an edge without one.
//
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   enable                CPU enable; gates CPU writes only
//   d_addr/d_dataout/d_we CPU data bus in; d_datain registered read data out
//   h_req/h_we/h_addr/h_wdata  host request, held until h_ack
//   h_ack/h_rdata         one-cycle completion pulse; read data held until the next host read
//   busy                  high while the array is being zeroed
//   wr_count              saturating count of accepted CPU writes
module data_mem_responder #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 16,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_dataout,
    input  logic              d_we,
    output logic [DATA_W-1:0] d_datain,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_ack,
    output logic [DATA_W-1:0] h_rdata,
    output logic              busy,
    output logic [15:0]       wr_count
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] clr_addr;

    logic              cpu_wr;
    logic              host_go;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdat;

    always_ff @(posedge clock) begin
        if (reset) begin
            if (CLEAR_ON_RESET) begin
                state <= ST_CLEAR;
            end else begin
                state <= ST_RUN;
            end
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus a single merged write port: the clear walk, the CPU
    // store and the host store never need the array on the same edge.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        cpu_wr    = 1'b0;
        host_go   = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = d_addr;
        mem_wdat  = d_dataout;
        case (state)
            ST_CLEAR: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_waddr = clr_addr;
                mem_wdat  = '0;
                if (clr_addr == '1) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                cpu_wr  = enable && d_we;
                // Not re-accepted while acking, so a held request gets one
                // access per two cycles.
                host_go = h_req && !h_ack && !cpu_wr;
                if (cpu_wr) begin
                    mem_we = 1'b1;
                end else if (host_go && h_we) begin
                    mem_we    = 1'b1;
                    mem_waddr = h_addr;
                    mem_wdat  = h_wdata;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // Array has no reset; only the clear walk zeroes it.
    always_ff @(posedge clock) begin
        if (!reset && mem_we) begin
            mem[mem_waddr] <= mem_wdat;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            clr_addr <= '0;
        end else if (state == ST_CLEAR) begin
            clr_addr <= clr_addr + 1'b1;
        end
    end

    // Reads sample the array before this edge's write lands (read-first).
    always_ff @(posedge clock) begin
        if (reset) begin
            d_datain <= '0;
            h_ack    <= 1'b0;
            h_rdata  <= '0;
            wr_count <= '0;
        end else begin
            h_ack <= host_go;
            if (state == ST_RUN) begin
                d_datain <= mem[d_addr];
            end
            if (host_go && !h_we) begin
                h_rdata <= mem[h_addr];
            end
            if (cpu_wr && (wr_count != 16'hFFFF)) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Purpose : directed bench for data_mem_responder; expectations are queued with the cycle they
//           are due and a monitor compares them against the outputs.
// Latency : n/a. Backpressure : n/a.
module tb_data_mem_responder;

    localparam logic [1:0] K_DATA = 2'd0;
    localparam logic [1:0] K_CNT  = 2'd1;
    localparam logic [1:0] K_BUSY = 2'd2;

    typedef struct packed {
        int          cyc;
        logic [1:0]  kind;
        logic [15:0] val;
    } exp_t;

    typedef struct packed {
        int          cyc;
        logic        chk;
        logic [15:0] val;
    } hexp_t;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [7:0]  d_addr;
    logic [15:0] d_dataout;
    logic        d_we;
    logic [15:0] d_datain;
    logic        h_req;
    logic        h_we;
    logic [7:0]  h_addr;
    logic [15:0] h_wdata;
    logic        h_ack;
    logic [15:0] h_rdata;
    logic        busy;
    logic [15:0] wr_count;

    exp_t  exp_q[$];
    hexp_t h_q[$];
    int    cyc;
    int    n_cmp;
    int    n_bad;

    data_mem_responder dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .d_addr    (d_addr),
        .d_dataout (d_dataout),
        .d_we      (d_we),
        .d_datain  (d_datain),
        .h_req     (h_req),
        .h_we      (h_we),
        .h_addr    (h_addr),
        .h_wdata   (h_wdata),
        .h_ack     (h_ack),
        .h_rdata   (h_rdata),
        .busy      (busy),
        .wr_count  (wr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic expect_at(input int c, input logic [1:0] k, input logic [15:0] v);
        exp_t e;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic expect_ack(input int c, input logic chk, input logic [15:0] v);
        hexp_t e;
        e.cyc = c;
        e.chk = chk;
        e.val = v;
        h_q.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    // Monitor: outputs are sampled on the falling edge, after edge cyc.
    always @(negedge clock) begin : monitor
        int          idx;
        logic [15:0] act;
        idx = 0;
        while (idx < exp_q.size()) begin
            if (exp_q[idx].cyc <= cyc) begin
                case (exp_q[idx].kind)
                    K_DATA:  act = d_datain;
                    K_CNT:   act = wr_count;
                    default: act = {15'd0, busy};
                endcase
                n_cmp = n_cmp + 1;
                if (exp_q[idx].cyc < cyc) begin
                    n_bad = n_bad + 1;
                    $display("FAIL check kind %0d due cyc %0d was skipped (now cyc %0d)",
                             exp_q[idx].kind, exp_q[idx].cyc, cyc);
                end else if (act !== exp_q[idx].val) begin
                    n_bad = n_bad + 1;
                    $display("FAIL %s @cyc %0d: got %h expected %h",
                             (exp_q[idx].kind == K_DATA) ? "d_datain" :
                             (exp_q[idx].kind == K_CNT)  ? "wr_count" : "busy",
                             cyc, act, exp_q[idx].val);
                end
                exp_q.delete(idx);
            end else begin
                idx = idx + 1;
            end
        end
        while (h_q.size() > 0 && h_q[0].cyc < cyc) begin
            n_cmp = n_cmp + 1;
            n_bad = n_bad + 1;
            $display("FAIL h_ack missing: due cyc %0d, still absent at cyc %0d", h_q[0].cyc, cyc);
            void'(h_q.pop_front());
        end
        if (h_ack === 1'b1) begin
            n_cmp = n_cmp + 1;
            if (h_q.size() == 0) begin
                n_bad = n_bad + 1;
                $display("FAIL h_ack unexpected @cyc %0d (h_rdata %h)", cyc, h_rdata);
            end else if (h_q[0].cyc != cyc) begin
                n_bad = n_bad + 1;
                $display("FAIL h_ack timing: got cyc %0d expected cyc %0d", cyc, h_q[0].cyc);
                void'(h_q.pop_front());
            end else begin
                if (h_q[0].chk && (h_rdata !== h_q[0].val)) begin
                    n_bad = n_bad + 1;
                    $display("FAIL h_rdata @cyc %0d: got %h expected %h", cyc, h_rdata, h_q[0].val);
                end
                void'(h_q.pop_front());
            end
        end
    end

    initial begin : stimulus
        int c;
        int r;
        n_cmp     = 0;
        n_bad     = 0;
        reset     = 1'b1;
        enable    = 1'b0;
        d_we      = 1'b0;
        d_addr    = 8'h00;
        d_dataout = 16'h0000;
        h_req     = 1'b0;
        h_we      = 1'b0;
        h_addr    = 8'h00;
        h_wdata   = 16'h0000;

        // Reset state after two reset edges.
        expect_at(2, K_BUSY, 16'd1);
        expect_at(2, K_DATA, 16'h0000);
        expect_at(2, K_CNT,  16'h0000);
        wait_until(2);

        // Clear walk: CPU stores during CLEAR are ignored and uncounted.
        reset = 1'b0;
        r = cyc;
        enable = 1'b1; d_we = 1'b1; d_addr = 8'h40; d_dataout = 16'hDEAD;
        expect_at(r + 1,   K_BUSY, 16'd1);
        expect_at(r + 100, K_DATA, 16'h0000);
        expect_at(r + 255, K_BUSY, 16'd1);
        expect_at(r + 256, K_BUSY, 16'd0);
        expect_at(r + 256, K_CNT,  16'h0000);
        wait_until(r + 256);

        // Host read of the top word after the walk.
        c = cyc;
        enable = 1'b0; d_we = 1'b0;
        h_req = 1'b1; h_we = 1'b0; h_addr = 8'hFF;
        expect_ack(c + 1, 1'b1, 16'h0000);
        @(negedge clock);
        h_req = 1'b0;

        // CPU store then load.
        c = cyc;
        enable = 1'b1; d_we = 1'b1; d_addr = 8'h10; d_dataout = 16'hABCD;
        expect_at(c + 1, K_DATA, 16'h0000);
        expect_at(c + 1, K_CNT,  16'd1);
        @(negedge clock);
        d_we = 1'b0;
        expect_at(c + 2, K_DATA, 16'hABCD);
        @(negedge clock);

        // Enable gating.
        c = cyc;
        enable = 1'b0; d_we = 1'b1; d_addr = 8'h11; d_dataout = 16'h1234;
        expect_at(c + 1, K_CNT, 16'd1);
        @(negedge clock);
        enable = 1'b1; d_we = 1'b0;
        expect_at(c + 2, K_DATA, 16'h0000);
        expect_at(c + 2, K_CNT,  16'd1);
        @(negedge clock);

        // Arbitration: host write stalls behind three CPU writes.
        c = cyc;
        d_we = 1'b1; d_addr = 8'h21; d_dataout = 16'h7777;
        h_req = 1'b1; h_we = 1'b1; h_addr = 8'h20; h_wdata = 16'h5555;
        expect_ack(c + 4, 1'b0, 16'h0000);
        expect_at(c + 3, K_CNT, 16'd4);
        repeat (3) @(negedge clock);
        d_we = 1'b0; d_addr = 8'h20;
        expect_at(c + 4, K_DATA, 16'h0000);
        @(negedge clock);
        h_req = 1'b0;
        expect_at(c + 5, K_DATA, 16'h5555);
        @(negedge clock);
        d_addr = 8'h21;
        expect_at(c + 6, K_DATA, 16'h7777);
        @(negedge clock);

        // Read-first collision on a CPU write.
        c = cyc;
        h_req = 1'b1; h_we = 1'b1; h_addr = 8'h30; h_wdata = 16'h0001; d_addr = 8'h31;
        expect_ack(c + 1, 1'b0, 16'h0000);
        expect_at(c + 1, K_DATA, 16'h0000);
        @(negedge clock);
        h_req = 1'b0;
        d_we = 1'b1; d_addr = 8'h30; d_dataout = 16'h0002;
        expect_at(c + 2, K_DATA, 16'h0001);
        expect_at(c + 2, K_CNT,  16'd5);
        @(negedge clock);
        d_we = 1'b0;
        expect_at(c + 3, K_DATA, 16'h0002);

        // Host write to the word the CPU is reading returns the old word.
        @(negedge clock);
        c = cyc;
        h_req = 1'b1; h_we = 1'b1; h_addr = 8'h31; h_wdata = 16'h00AA; d_addr = 8'h31;
        expect_ack(c + 1, 1'b0, 16'h0000);
        expect_at(c + 1, K_DATA, 16'h0000);
        expect_at(c + 2, K_DATA, 16'h00AA);
        @(negedge clock);
        h_req = 1'b0;

        // Held host read: one access per two cycles.
        @(negedge clock);
        c = cyc;
        h_req = 1'b1; h_we = 1'b0; h_addr = 8'h21;
        expect_ack(c + 1, 1'b1, 16'h7777);
        expect_ack(c + 3, 1'b1, 16'h7777);
        repeat (3) @(negedge clock);
        h_req = 1'b0;

        // Counter saturation.
        @(negedge clock);
        force dut.wr_count = 16'hFFFE;
        @(negedge clock);
        release dut.wr_count;
        c = cyc;
        enable = 1'b1; d_we = 1'b1; d_addr = 8'h40; d_dataout = 16'h0001;
        expect_at(c + 1, K_CNT, 16'hFFFF);
        expect_at(c + 3, K_CNT, 16'hFFFF);
        @(negedge clock);
        d_dataout = 16'h0002;
        @(negedge clock);
        d_dataout = 16'h0003;
        @(negedge clock);
        d_we = 1'b0;
        expect_at(c + 4, K_DATA, 16'h0003);
        @(negedge clock);

        // Mid-walk reset with a host request pending.
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        r = cyc;
        expect_at(r + 1,   K_CNT,  16'h0000);
        expect_at(r + 128, K_BUSY, 16'd1);
        wait_until(r + 128);
        reset = 1'b1;
        h_req = 1'b1; h_we = 1'b0; h_addr = 8'h10;
        expect_at(r + 129, K_CNT,  16'h0000);
        expect_at(r + 129, K_BUSY, 16'd1);
        expect_at(r + 129, K_DATA, 16'h0000);
        @(negedge clock);
        reset = 1'b0;
        r = cyc;
        expect_at(r + 255, K_BUSY, 16'd1);
        expect_at(r + 256, K_BUSY, 16'd0);
        wait_until(r + 255);
        h_req = 1'b0;
        wait_until(r + 256);

        // Re-request after the walk: the array is zero again.
        c = cyc;
        h_req = 1'b1; h_we = 1'b0; h_addr = 8'h10; d_addr = 8'h40;
        expect_ack(c + 1, 1'b1, 16'h0000);
        expect_at(c + 1, K_DATA, 16'h0000);
        @(negedge clock);
        h_req = 1'b0;
        repeat (3) @(negedge clock);

        n_cmp = n_cmp + 1;
        if (exp_q.size() != 0 || h_q.size() != 0) begin
            n_bad = n_bad + 1;
            $display("FAIL leftover expectations: %0d output checks, %0d acks outstanding",
                     exp_q.size(), h_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
